ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage MIPS pipeline, directly downstream of instruction decode. It consumes the decoded ALU control code, the two operands, the destination register and the memory/write-back control bits. It performs the ALU operation, evaluates BEQ, and computes the branch target, then registers everything into the EX/MEM pipeline register. Multiplies run on an iterative 32-cycle shift-add unit that stalls decode through a ready handshake.

## Interface
- `WIDTH`, default 32: datapath width; only 32 is supported.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `valid_in` in 1: decode presents a valid instruction.
- `ready_out` out 1: stage can accept; equals (state == IDLE); combinational from state only.
- `flush` in 1: kill any in-flight or accepted instruction (branch redirect).
- `ctrl` in 4: ALU control code.
- `rdDataA`, `rdDataB` in 32: operand A, and operand B (register value or immediate already selected).
- `store_data` in 32: rt value for SW.
- `imm` in 16: raw immediate, used for the branch offset.
- `pc_plus4` in 32: PC+4 of this instruction.
- `wr_addr` in 5: destination register.
- `RegWrite`, `MemRead`, `MemWrite`, `MemtoReg`, `branch` in 1 each: control bits from decode.
- `ex_valid` out 1: EX/MEM register holds a valid instruction.
- `ex_result` out 32: ALU or multiply result.
- `ex_store_data` out 32, `ex_wr_addr` out 5: registered copies of `store_data` and `wr_addr`.
- `ex_RegWrite`, `ex_MemRead`, `ex_MemWrite`, `ex_MemtoReg` out 1: registered control bits, forced to 0 whenever `ex_valid` = 0.
- `ex_zero` out 1: (`ex_result` == 0).
- `ex_branch_taken` out 1: `branch` & zero; valid only when `ex_valid` = 1.
- `ex_branch_target` out 32: `pc_plus4` + (sign-extended `imm` << 2).

## Operation
- Accept condition: `valid_in` & `ready_out` & !`flush`.
- ctrl encodings:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT (signed, result 1 or 0); 1100 NOR; 1000 MUL (low 32 bits).
  - Any other code yields result 0 and is otherwise treated as a normal single-cycle op.
- ADD, SUB and the branch target wrap modulo 2^32. There are no overflow exceptions.
- FSM states: IDLE and MUL.
  - IDLE → MUL on an accepted MUL. On that edge: mcand = A, mplier = B, acc = 0, cnt = 0, and the side-band fields are latched.
  - In MUL, each edge: if mplier[0], acc += mcand. Then mcand <<= 1, mplier >>= 1, cnt++.
  - When cnt == 31 at the edge (the 32nd iteration), the final acc is written into the EX/MEM register with `ex_valid` = 1, and the FSM returns to IDLE.
- A single-cycle op accepted in IDLE loads the EX/MEM register on the same edge with `ex_valid` = 1.
- Every edge with no accept and no MUL completion loads a bubble: `ex_valid` = 0 and all `ex_*` control bits = 0. Data fields may hold stale values.
- `flush` behaviour:
  - Has priority over everything else.
  - On an edge with `flush` = 1: FSM → IDLE, cnt = 0, and a bubble is loaded.
  - The instruction presented that cycle is not accepted.
- Reset: FSM IDLE, cnt 0, every `ex_*` output 0, `ex_valid` 0, `ready_out` 1.

## Timing
- Single-cycle ops: accepted at edge E0, output valid after E0 (latency 1). Back-to-back accepts are allowed every cycle.
- MUL: accepted at E0.
  - `ready_out` is 0 after E0 through E32.
  - Result and `ex_valid` = 1 appear after E32.
  - `ready_out` is 1 again after E32, so the next accept can occur at E33.
  - Bubbles are emitted after E1..E31.
- Decode must hold `valid_in` and its data stable while `ready_out` = 0. The stage ignores its inputs in MUL state.
- Reset asserted mid-MUL aborts immediately, asynchronously, with no result emitted.
- There is no back-pressure from MEM: the EX/MEM register updates every edge.

## Configuration
- `EX_MUL_EN`:
  - Defined: the MUL state, the iterative unit and the stall behaviour are compiled in.
  - Undefined: no MUL state exists, `ready_out` is tied to 1, and ctrl 1000 is treated as an unknown code (result 0, single cycle).

## Test plan
- Reset, then ADD with A = 0x7FFFFFFF, B = 1 → one cycle later `ex_result` = 0x80000000, `ex_valid` = 1, `ex_zero` = 0.
- SUB with A = 5, B = 5, `branch` = 1, `pc_plus4` = 0x100, `imm` = 0xFFFE → `ex_result` = 0, `ex_branch_taken` = 1, `ex_branch_target` = 0xF8.
- SLT with A = 0xFFFFFFFF, B = 1 → 1; then NOR with A = 0, B = 0 → 0xFFFFFFFF on the next cycle (back-to-back, no bubble).
- MUL with A = 0x12345, B = 0x10 (with `EX_MUL_EN`) → `ready_out` low for 32 cycles, bubbles throughout, then `ex_result` = 0x123450 with `ex_valid` = 1.
- MUL with A = 0xFFFFFFFF, B = 0xFFFFFFFF → `ex_result` = 0x00000001 after E32.
- MUL accepted, `flush` pulsed at E10 → bubble, `ready_out` = 1 the next cycle, no MUL result ever emitted. Repeat with `rst` mid-MUL → all outputs 0 immediately.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage MIPS pipeline.
// Performs the ALU operation, evaluates BEQ, and computes the branch target.
// Results are registered into the EX/MEM pipeline register every clock edge.
// Optional feature macro EX_MUL_EN adds an iterative 32-cycle shift-add
// multiplier for ctrl 1000. While it runs, decode is stalled via ready_out.
// Without EX_MUL_EN, ready_out is tied to 1 and ctrl 1000 is an unknown code.
module ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic             flush,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] rdDataA,
  input  logic [WIDTH-1:0] rdDataB,
  input  logic [WIDTH-1:0] store_data,
  input  logic [15:0]      imm,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic [4:0]       wr_addr,
  input  logic             RegWrite,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             MemtoReg,
  input  logic             branch,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_result,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [4:0]       ex_wr_addr,
  output logic             ex_RegWrite,
  output logic             ex_MemRead,
  output logic             ex_MemWrite,
  output logic             ex_MemtoReg,
  output logic             ex_zero,
  output logic             ex_branch_taken,
  output logic [WIDTH-1:0] ex_branch_target
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  // Everything that travels alongside the result into EX/MEM.
  typedef struct packed {
    logic [WIDTH-1:0] store_data;
    logic [4:0]       wr_addr;
    logic [WIDTH-1:0] target;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             branch;
  } side_t;

  logic             ex_valid_q, ex_valid_d;
  logic [WIDTH-1:0] ex_result_q, ex_result_d;
  side_t            ex_side_q, ex_side_d;

  logic             accept;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] branch_target;
  side_t            in_side;

`ifdef EX_MUL_EN
  localparam logic [3:0] CTRL_MUL = 4'b1000;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_next;
  logic [4:0]       cnt_q, cnt_d;
  side_t            mul_side_q, mul_side_d;

  assign ready_out = (state_q == S_IDLE);
  assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
`else
  assign ready_out = 1'b1;
`endif

  assign accept        = valid_in & ready_out & ~flush;
  assign branch_target = pc_plus4 + {{(WIDTH-18){imm[15]}}, imm, 2'b00};
  assign in_side       = '{store_data: store_data, wr_addr: wr_addr,
                           target: branch_target, reg_write: RegWrite,
                           mem_read: MemRead, mem_write: MemWrite,
                           mem_to_reg: MemtoReg, branch: branch};

  // Single-cycle ALU; unknown codes produce 0.
  always_comb begin
    case (ctrl)
      CTRL_AND: alu_result = rdDataA & rdDataB;
      CTRL_OR:  alu_result = rdDataA | rdDataB;
      CTRL_ADD: alu_result = rdDataA + rdDataB;
      CTRL_SUB: alu_result = rdDataA - rdDataB;
      CTRL_SLT: alu_result = {{(WIDTH-1){1'b0}}, ($signed(rdDataA) < $signed(rdDataB))};
      CTRL_NOR: alu_result = ~(rdDataA | rdDataB);
      default:  alu_result = '0;
    endcase
  end

  // Next-state: flush first, then multiply iteration, then a new accept; otherwise a bubble.
  always_comb begin
    // NOTE: every signal gets a default up front so no path leaves one unassigned (no latch).
    ex_valid_d           = 1'b0;
    ex_result_d          = ex_result_q;
    ex_side_d            = ex_side_q;
    ex_side_d.reg_write  = 1'b0;
    ex_side_d.mem_read   = 1'b0;
    ex_side_d.mem_write  = 1'b0;
    ex_side_d.mem_to_reg = 1'b0;
    ex_side_d.branch     = 1'b0;
`ifdef EX_MUL_EN
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    mul_side_d = mul_side_q;
`endif
    if (flush) begin
`ifdef EX_MUL_EN
      state_d = S_IDLE;
      cnt_d   = '0;
`endif
    end
`ifdef EX_MUL_EN
    else if (state_q == S_MUL) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        ex_valid_d  = 1'b1;
        ex_result_d = acc_next;
        ex_side_d   = mul_side_q;
        state_d     = S_IDLE;
        cnt_d       = '0;
      end
    end
    else if (accept && ctrl == CTRL_MUL) begin
      state_d    = S_MUL;
      mcand_d    = rdDataA;
      mplier_d   = rdDataB;
      acc_d      = '0;
      cnt_d      = '0;
      mul_side_d = in_side;
    end
`endif
    else if (accept) begin
      ex_valid_d  = 1'b1;
      ex_result_d = alu_result;
      ex_side_d   = in_side;
    end
  end

  // State and EX/MEM register, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_result_q <= '0;
      ex_side_q   <= '0;
`ifdef EX_MUL_EN
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      mul_side_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      ex_valid_q  <= ex_valid_d;
      ex_result_q <= ex_result_d;
      ex_side_q   <= ex_side_d;
`ifdef EX_MUL_EN
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mul_side_q  <= mul_side_d;
`endif
    end
  end

  assign ex_valid         = ex_valid_q;
  assign ex_result        = ex_result_q;
  assign ex_store_data    = ex_side_q.store_data;
  assign ex_wr_addr       = ex_side_q.wr_addr;
  assign ex_branch_target = ex_side_q.target;
  assign ex_RegWrite      = ex_side_q.reg_write;
  assign ex_MemRead       = ex_side_q.mem_read;
  assign ex_MemWrite      = ex_side_q.mem_write;
  assign ex_MemtoReg      = ex_side_q.mem_to_reg;
  // Zero flag is only meaningful for a valid entry; this keeps it 0 on bubbles and after reset.
  assign ex_zero          = ex_valid_q & (ex_result_q == '0);
  assign ex_branch_taken  = ex_side_q.branch & ex_zero;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized and directed checks of ex_stage against a behavioural model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, ready_out, flush;
  logic [3:0]  ctrl;
  logic [31:0] rdDataA, rdDataB, store_data, pc_plus4;
  logic [15:0] imm;
  logic [4:0]  wr_addr;
  logic        RegWrite, MemRead, MemWrite, MemtoReg, branch;
  logic        ex_valid;
  logic [31:0] ex_result, ex_store_data, ex_branch_target;
  logic [4:0]  ex_wr_addr;
  logic        ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg;
  logic        ex_zero, ex_branch_taken;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out), .flush(flush),
    .ctrl(ctrl), .rdDataA(rdDataA), .rdDataB(rdDataB), .store_data(store_data),
    .imm(imm), .pc_plus4(pc_plus4), .wr_addr(wr_addr), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .branch(branch),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_wr_addr(ex_wr_addr), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg), .ex_zero(ex_zero),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target)
  );

  // Reference ALU straight from the ctrl code table.
  function automatic logic [31:0] model_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
`ifdef EX_MUL_EN
      4'b1000: return a * b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] pc, input logic [15:0] im);
    logic signed [31:0] off;
    off = 32'(signed'(im));
    return pc + off * 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_side();
    store_data = $urandom;
    wr_addr    = 5'($urandom);
    pc_plus4   = $urandom;
    imm        = 16'($urandom);
    RegWrite   = 1'($urandom);
    MemRead    = 1'($urandom);
    MemWrite   = 1'($urandom);
    MemtoReg   = 1'($urandom);
    branch     = 1'($urandom);
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++;
    if ({ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_zero, ex_branch_taken} !== 7'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=0000000",
        {ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_zero, ex_branch_taken});
    end
    total++;
    if ({ex_result, ex_store_data, ex_branch_target, ex_wr_addr} !== 101'b0) begin
      bad++; $display("FAIL reset_data result=%h store=%h target=%h wr=%h want all 0",
        ex_result, ex_store_data, ex_branch_target, ex_wr_addr);
    end
    total++;
    if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready_out); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    valid_in = 1'b1; flush = 1'b0; ctrl = 4'b0010; rdDataA = 32'h7FFF_FFFF; rdDataB = 32'd1;
    randomize_side(); RegWrite = 1'b1; wr_addr = 5'd3;
    tick();
    total++;
    if (ex_result !== 32'h8000_0000) begin bad++; $display("FAIL add_result got=%h want=80000000", ex_result); end
    total++;
    if ({ex_valid, ex_zero, ex_RegWrite, ex_wr_addr} !== {1'b1, 1'b0, 1'b1, 5'd3}) begin
      bad++; $display("FAIL add_flags valid=%b zero=%b rw=%b wr=%0d want 1 0 1 3", ex_valid, ex_zero, ex_RegWrite, ex_wr_addr);
    end
    valid_in = 1'b0;
    tick();
    total++;
    if ({ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_branch_taken} !== 6'b0) begin
      bad++; $display("FAIL add_bubble got=%b want=000000",
        {ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_branch_taken});
    end
  endtask

  task automatic test_sub_branch();
    valid_in = 1'b1; ctrl = 4'b0110; rdDataA = 32'd5; rdDataB = 32'd5;
    randomize_side(); branch = 1'b1; pc_plus4 = 32'h100; imm = 16'hFFFE;
    tick();
    total++;
    if ({ex_result, ex_zero, ex_branch_taken} !== {32'd0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL beq_taken result=%h zero=%b taken=%b want 0 1 1", ex_result, ex_zero, ex_branch_taken);
    end
    total++;
    if (ex_branch_target !== 32'h0000_00F8) begin bad++; $display("FAIL beq_target got=%h want=000000f8", ex_branch_target); end
  endtask

  task automatic test_back_to_back();
    valid_in = 1'b1; ctrl = 4'b0111; rdDataA = 32'hFFFF_FFFF; rdDataB = 32'd1; randomize_side();
    tick();
    total++;
    if ({ex_valid, ex_result} !== {1'b1, 32'd1}) begin bad++; $display("FAIL slt got v=%b r=%h want v=1 r=1", ex_valid, ex_result); end
    ctrl = 4'b1100; rdDataA = 32'd0; rdDataB = 32'd0; randomize_side();
    tick();
    total++;
    if ({ex_valid, ex_result} !== {1'b1, 32'hFFFF_FFFF}) begin bad++; $display("FAIL nor got v=%b r=%h want v=1 r=ffffffff", ex_valid, ex_result); end
    valid_in = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [3:0]  c;
      logic [31:0] a, b, er;
      logic        v, f, ev;
      c = 4'($urandom);
`ifdef EX_MUL_EN
      if (c == 4'b1000) c = 4'b0010;
`endif
      a = $urandom;
      b = ($urandom_range(3) == 0) ? a : $urandom;
      v = ($urandom_range(3) != 0);
      f = ($urandom_range(9) == 0);
      valid_in = v; flush = f; ctrl = c; rdDataA = a; rdDataB = b; randomize_side();
      er = model_alu(c, a, b);
      ev = v && !f;
      tick();
      total++;
      if (ex_valid !== ev) begin bad++; $display("FAIL rand_valid[%0d] got=%b want=%b", i, ex_valid, ev); end
      total++;
      if (ready_out !== 1'b1) begin bad++; $display("FAIL rand_ready[%0d] got=%b want=1", i, ready_out); end
      if (ev) begin
        total++;
        if (ex_result !== er) begin bad++; $display("FAIL rand_result[%0d] ctrl=%b got=%h want=%h", i, c, ex_result, er); end
        total++;
        if ({ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_zero, ex_branch_taken}
            !== {RegWrite, MemRead, MemWrite, MemtoReg, er == 32'd0, branch && er == 32'd0}) begin
          bad++; $display("FAIL rand_ctl[%0d] got=%b want=%b", i,
            {ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_zero, ex_branch_taken},
            {RegWrite, MemRead, MemWrite, MemtoReg, er == 32'd0, branch && er == 32'd0});
        end
        total++;
        if ({ex_store_data, ex_wr_addr, ex_branch_target} !== {store_data, wr_addr, model_target(pc_plus4, imm)}) begin
          bad++; $display("FAIL rand_data[%0d] store=%h wr=%0d tgt=%h want %h %0d %h", i, ex_store_data, ex_wr_addr,
            ex_branch_target, store_data, wr_addr, model_target(pc_plus4, imm));
        end
      end else begin
        total++;
        if ({ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_zero, ex_branch_taken} !== 6'b0) begin
          bad++; $display("FAIL rand_bubble[%0d] got=%b want=000000", i,
            {ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_zero, ex_branch_taken});
        end
      end
    end
    valid_in = 1'b0; flush = 1'b0;
    tick();
  endtask

`ifdef EX_MUL_EN
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want, input bit scramble);
    logic [31:0] sd, tgt;
    logic [4:0]  wa;
    logic [4:0]  ctl;
    int          low_cnt;
    bit          bubble_ok;
    valid_in = 1'b1; flush = 1'b0; ctrl = 4'b1000; rdDataA = a; rdDataB = b; randomize_side();
    sd = store_data; wa = wr_addr; tgt = model_target(pc_plus4, imm);
    ctl = {RegWrite, MemRead, MemWrite, MemtoReg, branch};
    tick();
    low_cnt = 0; bubble_ok = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (ready_out === 1'b0) low_cnt++;
      if ({ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_branch_taken} !== 6'b0) bubble_ok = 1'b0;
      if (scramble) begin rdDataA = $urandom; rdDataB = $urandom; ctrl = 4'($urandom); end
      tick();
    end
    total++;
    if (low_cnt != 32) begin bad++; $display("FAIL mul_stall a=%h got=%0d low cycles want=32", a, low_cnt); end
    total++;
    if (!bubble_ok) begin bad++; $display("FAIL mul_bubbles a=%h got=non-bubble want=bubbles", a); end
    total++;
    if ({ex_valid, ready_out, ex_result} !== {1'b1, 1'b1, want}) begin
      bad++; $display("FAIL mul_result a=%h b=%h got v=%b rdy=%b r=%h want v=1 rdy=1 r=%h", a, b, ex_valid, ready_out, ex_result, want);
    end
    total++;
    if ({ex_store_data, ex_wr_addr, ex_branch_target, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg}
        !== {sd, wa, tgt, ctl[4:1]}) begin
      bad++; $display("FAIL mul_side got=%h/%0d/%h/%b want=%h/%0d/%h/%b", ex_store_data, ex_wr_addr, ex_branch_target,
        {ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg}, sd, wa, tgt, ctl[4:1]);
    end
    total++;
    if (ex_branch_taken !== (ctl[0] && want == 32'd0)) begin
      bad++; $display("FAIL mul_taken got=%b want=%b", ex_branch_taken, ctl[0] && want == 32'd0);
    end
    valid_in = 1'b0;
    tick();
  endtask

  task automatic test_mul();
    logic [31:0] a, b;
    run_mul(32'h0001_2345, 32'h10, 32'h0012_3450, 1'b0);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      run_mul(a, b, a * b, 1'b1);
    end
  endtask

  task automatic test_mul_flush();
    bit saw_valid;
    valid_in = 1'b1; flush = 1'b0; ctrl = 4'b1000; rdDataA = 32'd7; rdDataB = 32'd9; randomize_side();
    tick();
    for (int k = 0; k < 9; k++) tick();
    flush = 1'b1;
    tick();
    total++;
    if ({ex_valid, ready_out} !== 2'b01) begin bad++; $display("FAIL mul_flush got v=%b rdy=%b want v=0 rdy=1", ex_valid, ready_out); end
    flush = 1'b0; valid_in = 1'b0;
    saw_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ex_valid !== 1'b0 || ready_out !== 1'b1) saw_valid = 1'b1;
    end
    total++;
    if (saw_valid) begin bad++; $display("FAIL mul_flush_ghost got=result emitted want=none"); end
  endtask
`else
  task automatic test_mul_disabled();
    valid_in = 1'b1; flush = 1'b0; ctrl = 4'b1000; rdDataA = 32'd3; rdDataB = 32'd4; randomize_side();
    tick();
    total++;
    if ({ex_valid, ready_out, ex_result} !== {1'b1, 1'b1, 32'd0}) begin
      bad++; $display("FAIL mul_off got v=%b rdy=%b r=%h want v=1 rdy=1 r=0", ex_valid, ready_out, ex_result);
    end
    ctrl = 4'b0010;
    tick();
    total++;
    if ({ex_valid, ex_result} !== {1'b1, 32'd7}) begin bad++; $display("FAIL mul_off_next got v=%b r=%h want v=1 r=7", ex_valid, ex_result); end
    valid_in = 1'b0;
    tick();
  endtask
`endif

  task automatic test_async_reset();
    bit saw_valid;
    valid_in = 1'b1; flush = 1'b0; ctrl = 4'b0010; rdDataA = 32'd1; rdDataB = 32'd1; randomize_side();
    RegWrite = 1'b1; wr_addr = 5'd17;
    tick();
`ifdef EX_MUL_EN
    ctrl = 4'b1000; rdDataA = 32'hABCD; rdDataB = 32'h55;
    tick();
    for (int k = 0; k < 5; k++) tick();
`endif
    #2;
    rst = 1'b1; valid_in = 1'b0;
    #1;
    total++;
    if ({ex_valid, ex_RegWrite, ex_result, ex_wr_addr, ex_branch_target, ex_store_data} !== 103'b0) begin
      bad++; $display("FAIL async_rst got v=%b rw=%b r=%h wr=%0d tgt=%h sd=%h want all 0",
        ex_valid, ex_RegWrite, ex_result, ex_wr_addr, ex_branch_target, ex_store_data);
    end
    total++;
    if (ready_out !== 1'b1) begin bad++; $display("FAIL async_rst_ready got=%b want=1", ready_out); end
    tick();
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ex_valid !== 1'b0) saw_valid = 1'b1;
    end
    total++;
    if (saw_valid) begin bad++; $display("FAIL async_rst_ghost got=result emitted want=none"); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid_in = 1'b0; flush = 1'b0; ctrl = 4'b0; rdDataA = '0; rdDataB = '0;
    store_data = '0; imm = '0; pc_plus4 = '0; wr_addr = '0;
    RegWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0; branch = 1'b0;
    test_reset();
    test_add();
    test_sub_branch();
    test_back_to_back();
    test_random();
`ifdef EX_MUL_EN
    test_mul();
    test_mul_flush();
`else
    test_mul_disabled();
`endif
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
